// File: rtl/bcd_seg_scan_2digit.sv
// Two-digit multiplexed seven-segment driver fed by the binary-to-BCD encoder.
// Optional build macro LEADING_ZERO_BLANK_EN darkens the tens digit when it is 0.
module bcd_seg_scan_2digit #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] bcd,
  input  logic       valid,
  output logic [6:0] seg,
  output logic [1:0] dig_sel,
  output logic       err
);

  localparam int            CW  = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] TC  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {
    S_BLANK_U = 2'd0,
    S_UNITS   = 2'd1,
    S_BLANK_T = 2'd2,
    S_TENS    = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] div_cnt;
  logic [4:0]    disp_reg;
  logic          have_data;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Largest displayable value is 15, so tens=1 only allows units 0..5.
  function automatic logic bcd_legal(input logic [4:0] w);
    return (w[3:0] <= 4'd9) && !(w[4] && (w[3:0] > 4'd5));
  endfunction

  function automatic logic [6:0] tens_pattern(input logic t);
`ifdef LEADING_ZERO_BLANK_EN
    return t ? 7'h06 : 7'h00;
`else
    return t ? 7'h06 : 7'h3F;
`endif
  endfunction

  // Input capture: illegal words are dropped and flagged for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_reg  <= 5'd0;
      have_data <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= valid && !bcd_legal(bcd);
      if (valid && bcd_legal(bcd)) begin
        disp_reg  <= bcd;
        have_data <= 1'b1;
      end
    end
  end

  // Scan FSM: the lit digit is snapshotted only when leaving a blank slot,
  // so a capture in the middle of a digit slot never disturbs that slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_BLANK_U;
      div_cnt <= '0;
      seg     <= 7'h00;
      dig_sel <= 2'b00;
    end else begin
      case (state)
        S_BLANK_U: begin
          state   <= S_UNITS;
          div_cnt <= '0;
          dig_sel <= 2'b01;
          seg     <= have_data ? seg_decode(disp_reg[3:0]) : 7'h00;
        end
        S_UNITS: begin
          if (div_cnt == TC) begin
            state   <= S_BLANK_T;
            div_cnt <= '0;
            dig_sel <= 2'b00;
            seg     <= 7'h00;
          end else begin
            div_cnt <= div_cnt + ONE;
          end
        end
        S_BLANK_T: begin
          state   <= S_TENS;
          div_cnt <= '0;
          dig_sel <= 2'b10;
          seg     <= have_data ? tens_pattern(disp_reg[4]) : 7'h00;
        end
        S_TENS: begin
          if (div_cnt == TC) begin
            state   <= S_BLANK_U;
            div_cnt <= '0;
            dig_sel <= 2'b00;
            seg     <= 7'h00;
          end else begin
            div_cnt <= div_cnt + ONE;
          end
        end
        default: begin
          state   <= S_BLANK_U;
          div_cnt <= '0;
          dig_sel <= 2'b00;
          seg     <= 7'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan_2digit.sv
// Directed bench for bcd_seg_scan_2digit with SCAN_DIV=4 (scan period 10 cycles).
module tb_bcd_seg_scan_2digit;

  localparam int SCAN_DIV = 4;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] TENS_ZERO = 7'h00;
`else
  localparam logic [6:0] TENS_ZERO = 7'h3F;
`endif

  logic       clk;
  logic       rst_n;
  logic [4:0] bcd;
  logic       valid;
  logic [6:0] seg;
  logic [1:0] dig_sel;
  logic       err;

  int total;
  int bad;
  int cyc;

  bcd_seg_scan_2digit #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bcd     (bcd),
    .valid   (valid),
    .seg     (seg),
    .dig_sel (dig_sel),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required test completion");
    $fatal(1);
  end

  // cycle index since reset release; phase 0 and 5 are blank slots
  function automatic logic [1:0] exp_dig(input int c);
    int p;
    p = c % 10;
    if (p >= 1 && p <= 4) return 2'b01;
    if (p >= 6) return 2'b10;
    return 2'b00;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int p);
    while ((cyc % 10) != p) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    bcd   = 5'd0;
    #2;
    repeat (3) tick();
    total++; if (seg !== 7'h00) begin bad++; $display("FAIL rst_seg actual=%h required=00", seg); end
    total++; if (dig_sel !== 2'b00) begin bad++; $display("FAIL rst_dig actual=%b required=00", dig_sel); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err actual=%b required=0", err); end
    rst_n = 1'b1;
    cyc   = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (dig_sel !== exp_dig(cyc)) begin
        bad++; $display("FAIL rst_scan_dig cyc=%0d actual=%b required=%b", cyc, dig_sel, exp_dig(cyc));
      end
      total++;
      if (seg !== 7'h00) begin
        bad++; $display("FAIL rst_scan_seg cyc=%0d actual=%h required=00", cyc, seg);
      end
    end
  endtask

  task automatic test_legal_capture();
    run_to(2);
    valid = 1'b1; bcd = 5'b1_0011;
    tick();
    valid = 1'b0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL legal_err actual=%b required=0", err); end
    for (int r = 0; r < 2; r++) begin
      run_to(6);
      total++; if (seg !== 7'h06) begin bad++; $display("FAIL legal_tens_seg pass=%0d actual=%h required=06", r, seg); end
      total++; if (dig_sel !== 2'b10) begin bad++; $display("FAIL legal_tens_dig pass=%0d actual=%b required=10", r, dig_sel); end
      run_to(1);
      total++; if (seg !== 7'h4F) begin bad++; $display("FAIL legal_units_seg pass=%0d actual=%h required=4F", r, seg); end
      total++; if (dig_sel !== 2'b01) begin bad++; $display("FAIL legal_units_dig pass=%0d actual=%b required=01", r, dig_sel); end
    end
  endtask

  task automatic test_illegal();
    run_to(2);
    valid = 1'b1; bcd = 5'b0_1100;
    tick();
    valid = 1'b0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL illegal_a_err actual=%b required=1", err); end
    tick();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL illegal_a_err_clear actual=%b required=0", err); end
    valid = 1'b1; bcd = 5'b1_0110;
    tick();
    valid = 1'b0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL illegal_b_err actual=%b required=1", err); end
    tick();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL illegal_b_err_clear actual=%b required=0", err); end
    run_to(6);
    total++; if (seg !== 7'h06) begin bad++; $display("FAIL illegal_tens_seg actual=%h required=06", seg); end
    run_to(1);
    total++; if (seg !== 7'h4F) begin bad++; $display("FAIL illegal_units_seg actual=%h required=4F", seg); end
  endtask

  task automatic test_mid_slot();
    run_to(2);
    total++; if (seg !== 7'h4F) begin bad++; $display("FAIL mid_before actual=%h required=4F", seg); end
    valid = 1'b1; bcd = 5'b0_0010;
    tick();
    valid = 1'b0;
    total++; if (seg !== 7'h4F) begin bad++; $display("FAIL mid_hold3 actual=%h required=4F", seg); end
    tick();
    total++; if (seg !== 7'h4F) begin bad++; $display("FAIL mid_hold4 actual=%h required=4F", seg); end
    total++; if (dig_sel !== 2'b01) begin bad++; $display("FAIL mid_hold_dig actual=%b required=01", dig_sel); end
    run_to(6);
    total++; if (seg !== TENS_ZERO) begin bad++; $display("FAIL mid_tens_seg actual=%h required=%h", seg, TENS_ZERO); end
    run_to(1);
    total++; if (seg !== 7'h5B) begin bad++; $display("FAIL mid_units_seg actual=%h required=5B", seg); end
  endtask

  task automatic test_leading_zero();
    run_to(2);
    valid = 1'b1; bcd = 5'b0_0111;
    tick();
    valid = 1'b0;
    run_to(6);
    total++; if (seg !== TENS_ZERO) begin bad++; $display("FAIL lz_tens_seg actual=%h required=%h", seg, TENS_ZERO); end
    total++; if (dig_sel !== 2'b10) begin bad++; $display("FAIL lz_tens_dig actual=%b required=10", dig_sel); end
    run_to(1);
    total++; if (seg !== 7'h07) begin bad++; $display("FAIL lz_units_seg actual=%h required=07", seg); end
  endtask

  task automatic test_reset_midslot();
    run_to(2);
    valid = 1'b1; bcd = 5'b1_0101;
    tick();
    valid = 1'b0;
    run_to(7);
    total++; if (seg !== 7'h06) begin bad++; $display("FAIL rm_pre_seg actual=%h required=06", seg); end
    total++; if (dig_sel !== 2'b10) begin bad++; $display("FAIL rm_pre_dig actual=%b required=10", dig_sel); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (seg !== 7'h00) begin bad++; $display("FAIL rm_async_seg actual=%h required=00", seg); end
    total++; if (dig_sel !== 2'b00) begin bad++; $display("FAIL rm_async_dig actual=%b required=00", dig_sel); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rm_async_err actual=%b required=0", err); end
    repeat (2) tick();
    rst_n = 1'b1;
    cyc   = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (dig_sel !== exp_dig(cyc)) begin
        bad++; $display("FAIL rm_scan_dig cyc=%0d actual=%b required=%b", cyc, dig_sel, exp_dig(cyc));
      end
      total++;
      if (seg !== 7'h00) begin
        bad++; $display("FAIL rm_blank_seg cyc=%0d actual=%h required=00", cyc, seg);
      end
    end
    run_to(2);
    valid = 1'b1; bcd = 5'b0_1001;
    tick();
    valid = 1'b0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rm_nine_err actual=%b required=0", err); end
    run_to(6);
    total++; if (seg !== TENS_ZERO) begin bad++; $display("FAIL rm_nine_tens actual=%h required=%h", seg, TENS_ZERO); end
    run_to(1);
    total++; if (seg !== 7'h6F) begin bad++; $display("FAIL rm_nine_units actual=%h required=6F", seg); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst_n = 1'b0;
    valid = 1'b0;
    bcd   = 5'd0;
    test_reset();
    test_legal_capture();
    test_illegal();
    test_mid_slot();
    test_leading_zero();
    test_reset_midslot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
